// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes, register IDs.
package y86_pkg;

    typedef enum logic [3:0] {
        HALT   = 4'd0,
        NOP    = 4'd1,
        RRMOVQ = 4'd2,
        IRMOVQ = 4'd3,
        RMMOVQ = 4'd4,
        MRMOVQ = 4'd5,
        OPQ    = 4'd6,
        JXX    = 4'd7,
        CALL   = 4'd8,
        RET    = 4'd9,
        PUSHQ  = 4'd10,
        POPQ   = 4'd11
    } icode_t;

    typedef enum logic [2:0] {
        AOK = 3'd1,
        HLT = 3'd2,
        ADR = 3'd3,
        INS = 3'd4
    } stat_t;

    localparam logic [3:0] RNONE = 4'd15;
    localparam logic [3:0] RRSP  = 4'd4;

    // Map a raw status code onto the legal set; unknown codes become INS.
    function automatic stat_t norm_stat(input logic [2:0] s);
        stat_t r;
        case (s)
            3'd1:    r = AOK;
            3'd2:    r = HLT;
            3'd3:    r = ADR;
            3'd4:    r = INS;
            default: r = INS;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/regfile.sv
// Register file: NREG x W, two combinational read ports, two write ports.
// Port M wins when both write ports target the same register.
module regfile #(
    parameter int NREG = 15,
    parameter int W    = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [3:0]   dstE,
    input  logic [W-1:0] valE,
    input  logic [3:0]   dstM,
    input  logic [W-1:0] valM,
    input  logic [3:0]   srcA,
    input  logic [3:0]   srcB,
    output logic [W-1:0] valA,
    output logic [W-1:0] valB
);

    logic [W-1:0] regs_r [NREG];

    // Clear on reset; on a commit write each register from M first, else E.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= '0;
            end
        end else if (we) begin
            for (int i = 0; i < NREG; i++) begin
                if (dstM == 4'(i)) begin
                    regs_r[i] <= valM;
                end else if (dstE == 4'(i)) begin
                    regs_r[i] <= valE;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= regs_r[i];
            end
        end
    end

    // Read ports: pre-edge contents, out-of-range source (ID 15) reads zero.
    always_comb begin
        valA = '0;
        valB = '0;
        if (int'(srcA) < NREG) begin
            valA = regs_r[srcA];
        end else begin
            valA = '0;
        end
        if (int'(srcB) < NREG) begin
            valB = regs_r[srcB];
        end else begin
            valB = '0;
        end
    end

endmodule

// File: rtl/writeback.sv
// SEQ Y86-64 writeback: destination select, status FSM, retire counter,
// and the architectural register file.
module writeback
    import y86_pkg::*;
#(
    parameter int NREG = 15,
    parameter int W    = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_in,
    input  logic [3:0]   icode,
    input  logic [3:0]   rA,
    input  logic [3:0]   rB,
    input  logic         cnd,
    input  logic [W-1:0] valE,
    input  logic [W-1:0] valM,
    input  logic [2:0]   stat_in,
    input  logic [3:0]   srcA,
    input  logic [3:0]   srcB,
    output logic [W-1:0] valA,
    output logic [W-1:0] valB,
    output logic [2:0]   stat,
    output logic         halted,
    output logic [W-1:0] retired
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } wb_state_t;

    wb_state_t    state_r, state_next_s;
    stat_t        stat_r, stat_next_s;
    logic [W-1:0] retired_r;
    logic [3:0]   dst_e_s, dst_m_s;
    logic         commit_s;

    // Destination selection from the retiring instruction's fields.
    always_comb begin
        dst_e_s = RNONE;
        dst_m_s = RNONE;
        case (icode)
            RRMOVQ: begin
                if (cnd) begin
                    dst_e_s = rB;
                end else begin
                    dst_e_s = RNONE;
                end
            end
            IRMOVQ, OPQ:      dst_e_s = rB;
            CALL, RET, PUSHQ: dst_e_s = RRSP;
            POPQ: begin
                dst_e_s = RRSP;
                dst_m_s = rA;
            end
            MRMOVQ:  dst_m_s = rA;
            default: begin
                dst_e_s = RNONE;
                dst_m_s = RNONE;
            end
        endcase
    end

    // Status FSM next-state: commit on AOK, otherwise latch status and halt.
    always_comb begin
        state_next_s = state_r;
        stat_next_s  = stat_r;
        commit_s     = 1'b0;
        case (state_r)
            RUN: begin
                if (valid_in) begin
                    if (stat_in == AOK) begin
                        commit_s = 1'b1;
                    end else begin
                        state_next_s = HALTED;
                        stat_next_s  = norm_stat(stat_in);
                    end
                end else begin
                    state_next_s = RUN;
                end
            end
            HALTED:  state_next_s = HALTED;
            default: state_next_s = RUN;
        endcase
    end

    // Status FSM state and latched status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RUN;
            stat_r  <= AOK;
        end else begin
            state_r <= state_next_s;
            stat_r  <= stat_next_s;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^W.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_r <= '0;
        end else if (commit_s) begin
            retired_r <= retired_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            retired_r <= retired_r;
        end
    end

    regfile #(
        .NREG (NREG),
        .W    (W)
    ) u_regfile (
        .clk  (clk),
        .rst  (rst),
        .we   (commit_s),
        .dstE (dst_e_s),
        .valE (valE),
        .dstM (dst_m_s),
        .valM (valM),
        .srcA (srcA),
        .srcB (srcB),
        .valA (valA),
        .valB (valB)
    );

    assign stat    = stat_r;
    assign halted  = (state_r == HALTED);
    assign retired = retired_r;

endmodule

// File: doc/writeback.md
# writeback

Writeback stage of the SEQ Y86-64 processor: the write side of the register file that the decode stage reads. On each retiring instruction it selects the E and M destinations from `icode`, `rA`, `rB` and `cnd`, and commits `valE` and `valM` on the clock edge. It also latches the processor status and counts retired instructions. It owns the 15×64 register array and exposes the two combinational read ports decode uses.

## Interface
- `NREG`, 15, number of architectural registers (IDs 0–14; ID 15 = none)
- `W`, 64, data width
- `clk` input 1, rising-edge clock
- `rst` input 1, synchronous active-high reset
- `valid_in` input 1, one retiring instruction this cycle
- `icode` input 4, instruction code of retiring instruction
- `rA`, `rB` input 4, register specifiers of retiring instruction
- `cnd` input 1, condition result from execute (used by cmovXX)
- `valE` input W, execute result
- `valM` input W, memory read result
- `stat_in` input 3, upstream status: AOK=1, HLT=2, ADR=3, INS=4
- `srcA`, `srcB` input 4, decode read addresses
- `valA`, `valB` output W, decode read data
- `stat` output 3, latched processor status
- `halted` output 1, high once a non-AOK status has retired
- `retired` output W, count of committed instructions

## Operation
- Destination E:
  - icode 2 (rrmovq/cmovXX): `rB` if `cnd`, else 15.
  - icode 3 and 6: `rB`.
  - icode 8, 9, 10, 11: RSP (4).
  - Otherwise: 15.
- Destination M:
  - icode 5 and 11: `rA`.
  - Otherwise: 15.
- Destination 15 means no write.
- If dstE == dstM and both are ≠ 15 (popq %rsp), only the `valM` write occurs.
- Commit occurs when `valid_in` = 1 and state = RUN and `stat_in` = AOK:
  - Writes are performed.
  - `retired` increments by 1, wrapping modulo 2^W.
- Status FSM has two states, RUN and HALTED:
  - RUN → HALTED when `valid_in` = 1 and `stat_in` ≠ AOK. In that cycle:
    - `stat` ← `stat_in`.
    - No register writes occur and `retired` does not increment.
  - HALTED is absorbing until `rst`. In HALTED, `valid_in` is ignored and `stat` holds.
- `stat_in` values outside 1–4 are treated as INS (stat ← 4).
- Read ports:
  - `valA` = reg[`srcA`] and `valB` = reg[`srcB`], combinational.
  - Source 15 returns 0.
  - Reads return pre-edge contents; there is no write-through bypass.
- icode 0 with `stat_in` = HLT halts. icode 1 with AOK commits with no writes and increments `retired`.

## Timing
- Reset (`rst` high at a rising edge):
  - All registers = 0, `stat` = AOK (1), `halted` = 0, `retired` = 0, state = RUN.
  - Reset has priority over a simultaneous `valid_in`.
- Write latency: 1 edge. `valA`/`valB` reflect a commit in the cycle after the edge.
- `halted` goes high the cycle after the retiring edge of the non-AOK instruction.
- `valid_in` is sampled every edge, with no backpressure. Back-to-back instructions are legal each cycle.
- Reset asserted mid-operation (including in HALTED) returns to the reset state at the next edge. In-flight inputs in that cycle are discarded.

## Structure
- Shared package `y86_pkg` holds:
  - icode constants: HALT=0, NOP=1, RRMOVQ=2, IRMOVQ=3, RMMOVQ=4, MRMOVQ=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSHQ=10, POPQ=11.
  - Status codes: AOK, HLT, ADR, INS.
  - RNONE=15 and RRSP=4.
  - The `stat_t` typedef.
- Decode uses the same package.
- One sub-module, `regfile`:
  - 15×W array with 2 combinational read ports and 2 write ports.
  - Port M takes priority on an address match.
- Destination select, status FSM and counter live in `writeback`.

## Test plan
- Reset, then irmovq: `rB`=3, `valE`=0x55 → next cycle `srcB`=3 gives `valB`=0x55 and `retired`=1.
- cmovXX `rA`=2, `rB`=5, `valE`=7:
  - `cnd`=0 → reg5 unchanged (0).
  - `cnd`=1 → reg5=7.
- popq with `rA`=4: `valE`=0x108, `valM`=0xAB → reg4=0xAB (M wins).
- pushq: `valE`=0x100 → reg4=0x100 and reg[`rA`] unchanged.
- Same-cycle read: `srcA`=3 during the write of 0x99 to reg3 → `valA` still shows the old 0x55, then 0x99 next cycle.
- `valid_in` with `stat_in`=ADR on mrmovq `rA`=1:
  - Result: `stat`=3, `halted`=1, reg1 unchanged, `retired` frozen.
  - Subsequent AOK instructions are ignored.
  - `rst` restores `stat`=1 and `halted`=0.
